// File: rtl/st_sp_sequencer.sv
// st_sp_sequencer: owns the stack pointer and sequences stack-class commands
// (PUSH/POP/ADDSP/SUBSP/MOVSP/ADDS/LDRSP/STRSP) through the external
// combinational SP datapath and a single-port data memory.
// FSM: IDLE -> EXEC -> (MEM) -> DONE -> IDLE.
// Optional build macro ST_SP_LIMIT_CHECK_EN: suppresses SP updates outside
// [SP_LOW, SP_HIGH] and reports them on fault. The SP_LOW/SP_HIGH parameters
// exist only in that build.
module st_sp_sequencer #(
  parameter logic [31:0] SP_INIT = 32'h0000_1000
`ifdef ST_SP_LIMIT_CHECK_EN
  ,
  parameter logic [31:0] SP_LOW  = 32'h0000_0800,
  parameter logic [31:0] SP_HIGH = 32'h0000_1000
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [6:0]  cmd_imm7,
  input  logic [7:0]  cmd_imm8,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] dp_data_in,
  output logic [7:0]  dp_op_sel,
  output logic [6:0]  dp_immed7,
  output logic [7:0]  dp_immed8,
  input  logic [31:0] dp_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] sp,
  output logic        done,
  output logic [31:0] result,
  output logic        fault
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_ADDSP = 8'h04;
  localparam logic [7:0] OP_SUBSP = 8'h08;
  localparam logic [7:0] OP_MOVSP = 8'h10;
  localparam logic [7:0] OP_ADDS  = 8'h20;
  localparam logic [7:0] OP_LDRSP = 8'h40;
  localparam logic [7:0] OP_STRSP = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  r_op;
  logic [6:0]  r_imm7;
  logic [7:0]  r_imm8;
  logic [31:0] r_wdata;
  logic [31:0] r_ea;
  logic        r_fault;

  logic        needs_mem;
  logic        sp_update;
  logic [31:0] new_sp;
  logic        limit_bad;

  // Command classification for the latched opcode.
  assign needs_mem = (r_op == OP_PUSH) || (r_op == OP_POP) ||
                     (r_op == OP_LDRSP) || (r_op == OP_STRSP);
  assign sp_update = (r_op == OP_PUSH) || (r_op == OP_POP) || (r_op == OP_ADDSP) ||
                     (r_op == OP_SUBSP) || (r_op == OP_MOVSP);
  assign new_sp    = (r_op == OP_MOVSP) ? {r_wdata[31:2], 2'b00} : dp_result;

`ifdef ST_SP_LIMIT_CHECK_EN
  assign limit_bad = sp_update && ((new_sp < SP_LOW) || (new_sp > SP_HIGH));
`else
  assign limit_bad = 1'b0;
`endif

  assign dp_data_in = sp;
  assign fault      = (state == S_DONE) && r_fault;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and combinational outputs.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    dp_op_sel  = OP_NOP;
    dp_immed7  = '0;
    dp_immed8  = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = S_EXEC;
      end
      S_EXEC: begin
        dp_op_sel = r_op;
        dp_immed7 = r_imm7;
        dp_immed8 = r_imm8;
        state_next = (needs_mem && !limit_bad) ? S_MEM : S_DONE;
      end
      S_MEM: begin
        if (mem_ack) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, SP/result update and memory request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp        <= SP_INIT;
      r_op      <= OP_NOP;
      r_imm7    <= '0;
      r_imm8    <= '0;
      r_wdata   <= '0;
      r_ea      <= '0;
      r_fault   <= 1'b0;
      result    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Anything that is not a legal one-hot opcode runs as NOP.
            r_op    <= (cmd_op inside {OP_PUSH, OP_POP, OP_ADDSP, OP_SUBSP, OP_MOVSP,
                                       OP_ADDS, OP_LDRSP, OP_STRSP}) ? cmd_op : OP_NOP;
            r_imm7  <= cmd_imm7;
            r_imm8  <= cmd_imm8;
            r_wdata <= cmd_wdata;
            r_fault <= 1'b0;
          end
        end
        S_EXEC: begin
          r_ea    <= dp_result;
          r_fault <= limit_bad;
          if (!limit_bad) begin
            case (r_op)
              OP_PUSH: begin
                sp        <= dp_result;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {dp_result[31:2], 2'b00};
                mem_wdata <= r_wdata;
              end
              OP_POP: begin
                // SP moves only once the read data has returned.
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {sp[31:2], 2'b00};
              end
              OP_ADDSP, OP_SUBSP, OP_MOVSP: sp <= new_sp;
              OP_ADDS: result <= dp_result;
              OP_LDRSP: begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {dp_result[31:2], 2'b00};
              end
              OP_STRSP: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {dp_result[31:2], 2'b00};
                mem_wdata <= r_wdata;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_op == OP_POP) begin
              result <= mem_rdata;
              sp     <= r_ea;
            end else if (r_op == OP_LDRSP) begin
              result <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_st_sp_sequencer.sv
// tb_st_sp_sequencer: directed self-checking bench for st_sp_sequencer.
// A small behavioural model stands in for the external SP datapath; the
// memory side is driven by hand so ack timing is explicit in each step.
module tb_st_sp_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [6:0]  cmd_imm7;
  logic [7:0]  cmd_imm8;
  logic [31:0] cmd_wdata;
  logic [31:0] dp_data_in;
  logic [7:0]  dp_op_sel;
  logic [6:0]  dp_immed7;
  logic [7:0]  dp_immed8;
  logic [31:0] dp_result;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] sp;
  logic        done;
  logic [31:0] result;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  st_sp_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_imm7   (cmd_imm7),
    .cmd_imm8   (cmd_imm8),
    .cmd_wdata  (cmd_wdata),
    .dp_data_in (dp_data_in),
    .dp_op_sel  (dp_op_sel),
    .dp_immed7  (dp_immed7),
    .dp_immed8  (dp_immed8),
    .dp_result  (dp_result),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .sp         (sp),
    .done       (done),
    .result     (result),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // External SP datapath model.
  always_comb begin
    dp_result = dp_data_in;
    case (dp_op_sel)
      8'h01:               dp_result = dp_data_in - 32'd4;
      8'h02:               dp_result = dp_data_in + 32'd4;
      8'h04:               dp_result = dp_data_in + {25'd0, dp_immed7[4:0], 2'b00};
      8'h08:               dp_result = dp_data_in - {25'd0, dp_immed7[4:0], 2'b00};
      8'h20, 8'h40, 8'h80: dp_result = dp_data_in + {24'd0, dp_immed8[5:0], 2'b00};
      default:             dp_result = dp_data_in;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a command for one accept edge; returns at the negedge of EXEC.
  task automatic start(input logic [7:0] op, input logic [6:0] i7,
                       input logic [7:0] i8, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm7  = i7;
    cmd_imm8  = i8;
    cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One-cycle ack strobe; returns at the negedge after the ack edge.
  task automatic ack_mem(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 8'h00;
    cmd_imm7  = '0;
    cmd_imm8  = '0;
    cmd_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step(); step();

    // Reset state.
    check("rst_sp",       sp, 32'h0000_1000);
    check("rst_ready",    cmd_ready, 1);
    check("rst_mem_req",  mem_req, 0);
    check("rst_mem_we",   mem_we, 0);
    check("rst_done",     done, 0);
    check("rst_fault",    fault, 0);
    check("rst_result",   result, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_op_sel",   dp_op_sel, 8'h00);
    reset_n = 1'b1;
    step();

`ifndef ST_SP_LIMIT_CHECK_EN
    // PUSH 0xDEADBEEF with ack held off for two extra cycles.
    start(8'h01, 7'd0, 8'd0, 32'hDEAD_BEEF);
    check("push_exec_op", dp_op_sel, 8'h01);
    check("push_exec_in", dp_data_in, 32'h0000_1000);
    check("push_exec_rdy", cmd_ready, 0);
    check("push_exec_req", mem_req, 0);
    step();
    check("push_req",   mem_req, 1);
    check("push_we",    mem_we, 1);
    check("push_addr",  mem_addr, 32'h0000_0FFC);
    check("push_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("push_sp",    sp, 32'h0000_0FFC);
    check("push_mem_op_sel", dp_op_sel, 8'h00);
    step(); step();
    check("push_req_hold",  mem_req, 1);
    check("push_addr_hold", mem_addr, 32'h0000_0FFC);
    check("push_no_done",   done, 0);
    ack_mem(32'h0);
    check("push_done",     done, 1);
    check("push_req_drop", mem_req, 0);
    step();
    check("push_done_pulse", done, 0);
    check("push_ready",      cmd_ready, 1);

    // POP with ack in the first MEM cycle.
    start(8'h02, 7'd0, 8'd0, 32'h0);
    check("pop_exec_op", dp_op_sel, 8'h02);
    step();
    check("pop_req",  mem_req, 1);
    check("pop_we",   mem_we, 0);
    check("pop_addr", mem_addr, 32'h0000_0FFC);
    check("pop_sp_hold", sp, 32'h0000_0FFC);
    ack_mem(32'hDEAD_BEEF);
    check("pop_done",   done, 1);
    check("pop_result", result, 32'hDEAD_BEEF);
    check("pop_sp",     sp, 32'h0000_1000);
    step();

    // ADDS imm8=0xFF: upper imm bits ignored, done at accept+2.
    start(8'h20, 7'd0, 8'hFF, 32'h0);
    check("adds_exec_done", done, 0);
    step();
    check("adds_done",   done, 1);
    check("adds_result", result, 32'h0000_10FC);
    check("adds_sp",     sp, 32'h0000_1000);
    check("adds_no_req", mem_req, 0);
    step();

    // SUBSP imm7=0x7F.
    start(8'h08, 7'h7F, 8'd0, 32'h0);
    step();
    check("subsp_done", done, 1);
    check("subsp_sp",   sp, 32'h0000_0F84);
    step();

    // LDRSP imm8=3.
    start(8'h40, 7'd0, 8'd3, 32'h0);
    step();
    check("ldrsp_req",  mem_req, 1);
    check("ldrsp_we",   mem_we, 0);
    check("ldrsp_addr", mem_addr, 32'h0000_0F90);
    ack_mem(32'h1234_5678);
    check("ldrsp_result", result, 32'h1234_5678);
    check("ldrsp_sp",     sp, 32'h0000_0F84);
    step();

    // NOP and a non-one-hot opcode both behave as NOP.
    start(8'h00, 7'd0, 8'd0, 32'h0);
    check("nop_op_sel", dp_op_sel, 8'h00);
    step();
    check("nop_done", done, 1);
    check("nop_sp",   sp, 32'h0000_0F84);
    step();
    start(8'h03, 7'd0, 8'd0, 32'h0);
    check("bad_op_sel", dp_op_sel, 8'h00);
    step();
    check("bad_done",   done, 1);
    check("bad_sp",     sp, 32'h0000_0F84);
    check("bad_result", result, 32'h1234_5678);
    check("bad_no_req", mem_req, 0);
    step();

    // cmd_valid held while busy with a different command is ignored.
    cmd_valid = 1'b1; cmd_op = 8'h04; cmd_imm7 = 7'd1;
    @(posedge clk); @(negedge clk);
    cmd_op = 8'h10; cmd_wdata = 32'h0;
    check("busy_ready", cmd_ready, 0);
    step();
    cmd_valid = 1'b0;
    check("busy_done", done, 1);
    check("busy_sp",   sp, 32'h0000_0F88);
    step();
    check("busy_sp_after", sp, 32'h0000_0F88);

    // mem_ack outside MEM is ignored.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("stray_ack_done", done, 0);
    check("stray_ack_sp",   sp, 32'h0000_0F88);

    // MOVSP masks the low bits; PUSH from 0 wraps.
    start(8'h10, 7'd0, 8'd0, 32'h0000_0003);
    step();
    check("movsp_sp", sp, 32'h0000_0000);
    step();
    start(8'h01, 7'd0, 8'd0, 32'h5A5A_5A5A);
    step();
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    check("wrap_sp",   sp, 32'hFFFF_FFFC);
    ack_mem(32'h0);
    check("wrap_done", done, 1);
    step();
`endif

    // STRSP with ack withheld, then reset mid-operation.
    start(8'h10, 7'd0, 8'd0, 32'h0000_0900);
    step(); step();
    check("strsp_base_sp", sp, 32'h0000_0900);
    start(8'h80, 7'd0, 8'd2, 32'h0000_AA55);
    step();
    check("strsp_req",   mem_req, 1);
    check("strsp_we",    mem_we, 1);
    check("strsp_addr",  mem_addr, 32'h0000_0908);
    check("strsp_wdata", mem_wdata, 32'h0000_AA55);
    for (int i = 0; i < 5; i++) step();
    check("strsp_req_hold",  mem_req, 1);
    check("strsp_addr_hold", mem_addr, 32'h0000_0908);
    check("strsp_sp",        sp, 32'h0000_0900);
    reset_n = 1'b0;
    #1;
    check("midrst_req",   mem_req, 0);
    check("midrst_sp",    sp, 32'h0000_1000);
    check("midrst_ready", cmd_ready, 1);
    step();
    reset_n = 1'b1;
    step();

`ifdef ST_SP_LIMIT_CHECK_EN
    // POP above SP_HIGH and MOVSP below SP_LOW are suppressed with fault.
    start(8'h02, 7'd0, 8'd0, 32'h0);
    check("lim_pop_exec_req", mem_req, 0);
    step();
    check("lim_pop_done",  done, 1);
    check("lim_pop_fault", fault, 1);
    check("lim_pop_req",   mem_req, 0);
    check("lim_pop_sp",    sp, 32'h0000_1000);
    step();
    check("lim_fault_pulse", fault, 0);
    start(8'h10, 7'd0, 8'd0, 32'h0000_07FC);
    step();
    check("lim_movsp_fault", fault, 1);
    check("lim_movsp_sp",    sp, 32'h0000_1000);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
